// File: rtl/debug_pkg.sv
// Shared definitions for the debugger command unit: host command codes,
// default response bytes and the load-parser state encoding.
package debug_pkg;

   localparam logic [7:0] CMD_LOAD      = 8'h07;
   localparam logic [7:0] CMD_RUN       = 8'h08;
   localparam logic [7:0] CMD_STEP_MODE = 8'h09;
   localparam logic [7:0] CMD_STEP      = 8'h0A;
   localparam logic [7:0] CMD_HALT      = 8'h0B;

   localparam logic [7:0] ACK_DEFAULT = 8'hA5;
   localparam logic [7:0] NAK_DEFAULT = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEN   = 2'd1,
      ST_DATA  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

endpackage

// File: rtl/debug_resp_tx.sv
// One-entry response buffer in front of the UART transmitter. A newer
// response replaces a pending one; each buffered byte is launched once.
module debug_resp_tx (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_resp_vld,
   input  logic [7:0] i_resp_byte,
   input  logic       i_tx_busy,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data
);

   logic       r_pend;
   logic [7:0] r_pend_byte;
   logic       r_tx_start;
   logic [7:0] r_tx_data;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pend      <= 1'b0;
         r_pend_byte <= 8'h00;
         r_tx_start  <= 1'b0;
         r_tx_data   <= 8'h00;
      end else begin
         r_tx_start <= 1'b0;
         // Skip the cycle right after a launch: the transmitter may not show busy yet.
         if (r_pend && !i_tx_busy && !r_tx_start) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_pend_byte;
            r_pend     <= 1'b0;
         end
         if (i_resp_vld) begin
            r_pend      <= 1'b1;
            r_pend_byte <= i_resp_byte;
         end
      end
   end

   assign o_tx_start = r_tx_start;
   assign o_tx_data  = r_tx_data;

endmodule

// File: rtl/debug_cmd_unit.sv
// Debugger front end: decodes host bytes, loads little-endian program words
// into instruction memory and drives the core's run/step/reset controls.
module debug_cmd_unit
   import debug_pkg::*;
#(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          MAX_INSTRUCTION = 64,
   parameter int          TIMEOUT_CYCLES  = 1000000,
   parameter logic [7:0]  ACK_BYTE        = ACK_DEFAULT,
   parameter logic [7:0]  NAK_BYTE        = NAK_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   input  logic                  i_tx_busy,
   input  logic                  i_cpu_halt,
   output logic                  o_tx_start,
   output logic [7:0]            o_tx_data,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [31:0]           o_imem_data,
   output logic                  o_cpu_rst,
   output logic                  o_run,
   output logic                  o_step,
   output logic                  o_step_mode,
   output logic                  o_loaded
);

   localparam int         TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAX_LEN = 8'(MAX_INSTRUCTION);

   state_t                r_state;
   logic [7:0]            r_len;
   logic [ADDR_WIDTH-1:0] r_word_idx;
   logic [1:0]            r_byte_idx;
   logic [23:0]           r_word;
   logic [TMO_W-1:0]      r_tmo;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_data;
   logic                  r_cpu_rst;
   logic                  r_run;
   logic                  r_step;
   logic                  r_step_mode;
   logic                  r_loaded;
   logic                  r_resp_vld;
   logic [7:0]            r_resp_byte;

   logic                  w_counting;
   logic                  w_tmo_hit;
   logic [ADDR_WIDTH-1:0] w_next_idx;
   logic                  w_last;

   assign w_counting = (r_state == ST_LEN) || (r_state == ST_DATA);
   assign w_tmo_hit  = w_counting && !i_rx_done &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_next_idx = r_word_idx + 1'b1;
   assign w_last     = (w_next_idx == ADDR_WIDTH'(r_len));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_len       <= 8'h00;
         r_word_idx  <= '0;
         r_byte_idx  <= 2'd0;
         r_word      <= 24'h0;
         r_tmo       <= '0;
         r_imem_we   <= 1'b0;
         r_imem_addr <= '0;
         r_imem_data <= 32'h0;
         r_cpu_rst   <= 1'b0;
         r_run       <= 1'b0;
         r_step      <= 1'b0;
         r_step_mode <= 1'b0;
         r_loaded    <= 1'b0;
         r_resp_vld  <= 1'b0;
         r_resp_byte <= 8'h00;
      end else begin
         r_resp_vld <= 1'b0;
         r_step     <= 1'b0;
         r_imem_we  <= 1'b0;

         if (i_rx_done || !w_counting)
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_rx_done) begin
                  case (i_rx_data)
                     CMD_LOAD: begin
                        r_state   <= ST_LEN;
                        r_cpu_rst <= 1'b1;
                     end
                     CMD_RUN: begin
                        r_resp_vld <= 1'b1;
                        if (r_loaded) begin
                           r_run       <= 1'b1;
                           r_step_mode <= 1'b0;
                           r_resp_byte <= ACK_BYTE;
                        end else begin
                           r_resp_byte <= NAK_BYTE;
                        end
                     end
                     CMD_STEP_MODE: begin
                        r_run       <= 1'b0;
                        r_step_mode <= 1'b1;
                        r_resp_vld  <= 1'b1;
                        r_resp_byte <= ACK_BYTE;
                     end
                     CMD_STEP: begin
                        r_resp_vld <= 1'b1;
                        if (r_step_mode && r_loaded) begin
                           r_step      <= 1'b1;
                           r_resp_byte <= ACK_BYTE;
                        end else begin
                           r_resp_byte <= NAK_BYTE;
                        end
                     end
                     CMD_HALT: begin
                        r_run       <= 1'b0;
                        r_resp_vld  <= 1'b1;
                        r_resp_byte <= ACK_BYTE;
                     end
                     default: begin
                        r_resp_vld  <= 1'b1;
                        r_resp_byte <= NAK_BYTE;
                     end
                  endcase
               end
            end

            ST_LEN: begin
               if (i_rx_done) begin
                  if (i_rx_data == 8'h00 || i_rx_data > MAX_LEN) begin
                     r_state     <= ST_IDLE;
                     r_cpu_rst   <= 1'b0;
                     r_resp_vld  <= 1'b1;
                     r_resp_byte <= NAK_BYTE;
                  end else begin
                     r_len      <= i_rx_data;
                     r_word_idx <= '0;
                     r_byte_idx <= 2'd0;
                     r_run      <= 1'b0;
                     r_loaded   <= 1'b0;
                     r_state    <= ST_DATA;
                  end
               end else if (w_tmo_hit) begin
                  r_state     <= ST_IDLE;
                  r_cpu_rst   <= 1'b0;
                  r_resp_vld  <= 1'b1;
                  r_resp_byte <= NAK_BYTE;
               end
            end

            ST_DATA: begin
               if (i_rx_done) begin
                  r_byte_idx <= r_byte_idx + 1'b1;
                  case (r_byte_idx)
                     2'd0: r_word[7:0]   <= i_rx_data;
                     2'd1: r_word[15:8]  <= i_rx_data;
                     2'd2: r_word[23:16] <= i_rx_data;
                     default: begin
                        r_imem_we   <= 1'b1;
                        r_imem_addr <= r_word_idx;
                        r_imem_data <= {i_rx_data, r_word};
                        r_state     <= ST_WRITE;
                     end
                  endcase
               end else if (w_tmo_hit) begin
                  r_state     <= ST_IDLE;
                  r_cpu_rst   <= 1'b0;
                  r_resp_vld  <= 1'b1;
                  r_resp_byte <= NAK_BYTE;
               end
            end

            ST_WRITE: begin
               r_word_idx <= w_next_idx;
               if (w_last) begin
                  r_loaded    <= 1'b1;
                  r_cpu_rst   <= 1'b0;
                  r_resp_vld  <= 1'b1;
                  r_resp_byte <= ACK_BYTE;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state <= ST_DATA;
                  // A byte arriving during the write cycle starts the next word.
                  if (i_rx_done) begin
                     r_word[7:0] <= i_rx_data;
                     r_byte_idx  <= 2'd1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase

         if (i_cpu_halt)
            r_run <= 1'b0;
      end
   end

   debug_resp_tx u_resp_tx (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_resp_vld  (r_resp_vld),
      .i_resp_byte (r_resp_byte),
      .i_tx_busy   (i_tx_busy),
      .o_tx_start  (o_tx_start),
      .o_tx_data   (o_tx_data)
   );

   assign o_imem_we   = r_imem_we;
   assign o_imem_addr = r_imem_addr;
   assign o_imem_data = r_imem_data;
   assign o_cpu_rst   = r_cpu_rst;
   assign o_run       = r_run;
   assign o_step      = r_step;
   assign o_step_mode = r_step_mode;
   assign o_loaded    = r_loaded;

endmodule

// File: tb/tb_debug_cmd_unit.sv
// Bench for debug_cmd_unit: directed scenarios plus a randomized command
// stream, checked against a command-level model of the debugger protocol.
module tb_debug_cmd_unit;

   localparam int         AW   = 32;
   localparam int         MAXI = 64;
   localparam int         TMO  = 300;
   localparam logic [7:0] ACK  = 8'hA5;
   localparam logic [7:0] NAK  = 8'hEE;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [7:0]    i_rx_data = 8'h00;
   logic          i_rx_done = 1'b0;
   logic          i_tx_busy = 1'b0;
   logic          i_cpu_halt = 1'b0;
   logic          o_tx_start;
   logic [7:0]    o_tx_data;
   logic          o_imem_we;
   logic [AW-1:0] o_imem_addr;
   logic [31:0]   o_imem_data;
   logic          o_cpu_rst;
   logic          o_run;
   logic          o_step;
   logic          o_step_mode;
   logic          o_loaded;

   always #10 i_clk = ~i_clk;

   debug_cmd_unit #(
      .ADDR_WIDTH(AW), .MAX_INSTRUCTION(MAXI), .TIMEOUT_CYCLES(TMO),
      .ACK_BYTE(ACK), .NAK_BYTE(NAK)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .i_tx_busy(i_tx_busy), .i_cpu_halt(i_cpu_halt), .o_tx_start(o_tx_start),
      .o_tx_data(o_tx_data), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
      .o_imem_data(o_imem_data), .o_cpu_rst(o_cpu_rst), .o_run(o_run),
      .o_step(o_step), .o_step_mode(o_step_mode), .o_loaded(o_loaded)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Observed traffic, gathered once per cycle on the falling edge.
   logic [7:0]  got_tx[$];
   logic [63:0] got_wr[$];
   int          step_pulses = 0;
   bit          step_dbl = 0;
   bit          prev_step = 0;
   bit          wr_no_rst = 0;

   // Protocol-level model of the host-visible state.
   bit m_loaded = 0;
   bit m_step_mode = 0;
   bit m_run = 0;
   int m_steps = 0;

   task automatic tick();
      @(negedge i_clk);
      if (o_tx_start) got_tx.push_back(o_tx_data);
      if (o_imem_we) begin
         got_wr.push_back({o_imem_addr[31:0], o_imem_data});
         if (!o_cpu_rst) wr_no_rst = 1;
      end
      if (o_step) begin
         step_pulses++;
         if (prev_step) step_dbl = 1;
      end
      prev_step = o_step;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
      i_rx_data = 8'($urandom);
      repeat (gap) tick();
   endtask

   function automatic logic [7:0] ref_cmd(input logic [7:0] b);
      case (b)
         8'h08: begin
            if (!m_loaded) return NAK;
            m_run = 1; m_step_mode = 0; return ACK;
         end
         8'h09: begin m_run = 0; m_step_mode = 1; return ACK; end
         8'h0A: begin
            if (!(m_step_mode && m_loaded)) return NAK;
            m_steps++; return ACK;
         end
         8'h0B: begin m_run = 0; return ACK; end
         default: return NAK;
      endcase
   endfunction

   // Sends one non-load command; got_tx afterwards holds only its response.
   task automatic send_cmd(input logic [7:0] b, output logic [7:0] exp);
      exp = ref_cmd(b);
      got_tx.delete();
      send_byte(b, 8);
   endtask

   task automatic load_prog(input int n, input logic [31:0] w[$]);
      got_tx.delete();
      got_wr.delete();
      wr_no_rst = 0;
      send_byte(8'h07, 6);
      send_byte(8'(n), 6);
      m_loaded = 0; m_run = 0;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++)
            send_byte(w[i][8*k +: 8], 2);
      repeat (8) tick();
      m_loaded = 1;
   endtask

   task automatic test_reset();
      #5 i_rst = 1'b0;
      #1;
      n_cmp++;
      if ({o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_datapath: got start=%b data=%h we=%b addr=%h wdata=%h, want all 0",
                  o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data);
      end
      n_cmp++;
      if ({o_cpu_rst, o_run, o_step, o_step_mode, o_loaded} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got cpu_rst/run/step/mode/loaded=%b, want 00000",
                  {o_cpu_rst, o_run, o_step, o_step_mode, o_loaded});
      end
      repeat (3) tick();
      i_rst = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_no_load();
      logic [7:0] exp;
      int s0;
      send_cmd(8'h08, exp);
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== exp || o_run !== 1'b0) begin
         n_fail++;
         $display("FAIL run_unloaded: got %0d bytes first=%h run=%b, want 1 byte %h run=0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, o_run, exp);
      end
      s0 = step_pulses;
      send_cmd(8'h0A, exp);
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== exp || step_pulses != s0) begin
         n_fail++;
         $display("FAIL step_no_mode: got %0d bytes first=%h pulses=%0d, want 1 byte %h pulses=0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, step_pulses - s0, exp);
      end
   endtask

   task automatic test_load();
      logic [31:0] w[$];
      bit rst_seen;
      w = '{32'h3C010003, 32'h3C020001};
      got_tx.delete(); got_wr.delete(); wr_no_rst = 0;
      send_byte(8'h07, 6);
      send_byte(8'h02, 6);
      rst_seen = o_cpu_rst;
      m_loaded = 0; m_run = 0;
      foreach (w[i]) for (int k = 0; k < 4; k++) send_byte(w[i][8*k +: 8], 2);
      repeat (8) tick();
      m_loaded = 1;
      n_cmp++;
      if (got_wr.size() != 2 || got_wr[0] !== {32'd0, w[0]} || got_wr[1] !== {32'd1, w[1]}) begin
         n_fail++;
         $display("FAIL load_writes: got %0d writes first=%h, want 2 writes 000000003c010003,000000013c020001",
                  got_wr.size(), got_wr.size() ? got_wr[0] : 64'h0);
      end
      n_cmp++;
      if (!rst_seen || wr_no_rst || o_cpu_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL load_cpu_rst: got mid=%b at_write_low=%b after=%b, want 1 0 0",
                  rst_seen, wr_no_rst, o_cpu_rst);
      end
      n_cmp++;
      if (o_loaded !== 1'b1 || got_tx.size() != 1 || got_tx[0] !== ACK) begin
         n_fail++;
         $display("FAIL load_ack: got loaded=%b %0d bytes first=%h, want loaded=1 1 byte a5",
                  o_loaded, got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00);
      end
      // Random-content programs of random length.
      for (int t = 0; t < 3; t++) begin
         int n;
         n = $urandom_range(1, 6);
         w.delete();
         for (int i = 0; i < n; i++) w.push_back($urandom);
         load_prog(n, w);
         n_cmp++;
         if (got_wr.size() != n || got_tx.size() != 1 || got_tx[0] !== ACK || o_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_load_%0d: got %0d writes %0d acks loaded=%b, want %0d writes 1 ack loaded=1",
                     t, got_wr.size(), got_tx.size(), o_loaded, n);
         end
         for (int i = 0; i < n && i < got_wr.size(); i++) begin
            n_cmp++;
            if (got_wr[i] !== {32'(i), w[i]}) begin
               n_fail++;
               $display("FAIL rand_load_%0d_word%0d: got %h, want %h", t, i, got_wr[i], {32'(i), w[i]});
            end
         end
      end
   endtask

   task automatic test_run_halt();
      logic [7:0] exp;
      send_cmd(8'h08, exp);
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== exp || o_run !== 1'b1 || o_step_mode !== 1'b0) begin
         n_fail++;
         $display("FAIL run_ack: got %0d bytes first=%h run=%b mode=%b, want 1 byte %h run=1 mode=0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, o_run, o_step_mode, exp);
      end
      i_cpu_halt = 1'b1;
      tick();
      m_run = 0;
      n_cmp++;
      if (o_run !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_clears_run: got run=%b, want 0", o_run);
      end
      send_cmd(8'h08, exp);
      m_run = 0;
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== exp || o_run !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_vs_run: got %0d bytes first=%h run=%b, want 1 byte %h run=0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, o_run, exp);
      end
      i_cpu_halt = 1'b0;
      tick();
   endtask

   task automatic test_step();
      logic [7:0] exp;
      int s0, acks;
      s0 = step_pulses; step_dbl = 0;
      send_cmd(8'h0A, exp);
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== exp || step_pulses != s0) begin
         n_fail++;
         $display("FAIL step_in_run_mode: got %0d bytes first=%h pulses=%0d, want 1 byte %h pulses=0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, step_pulses - s0, exp);
      end
      acks = 0;
      send_cmd(8'h09, exp);
      if (got_tx.size() == 1 && got_tx[0] === ACK) acks++;
      for (int i = 0; i < 3; i++) begin
         send_cmd(8'h0A, exp);
         if (got_tx.size() == 1 && got_tx[0] === ACK) acks++;
      end
      n_cmp++;
      if (acks != 4 || step_pulses - s0 != 3 || step_dbl || o_step_mode !== 1'b1) begin
         n_fail++;
         $display("FAIL step_seq: got acks=%0d pulses=%0d wide=%b mode=%b, want acks=4 pulses=3 wide=0 mode=1",
                  acks, step_pulses - s0, step_dbl, o_step_mode);
      end
   endtask

   task automatic test_bad_len();
      logic [7:0] lens [2];
      lens[0] = 8'h00;
      lens[1] = 8'h41;
      for (int i = 0; i < 2; i++) begin
         got_tx.delete(); got_wr.delete();
         send_byte(8'h07, 6);
         send_byte(lens[i], 8);
         n_cmp++;
         if (got_tx.size() != 1 || got_tx[0] !== NAK || got_wr.size() != 0 || o_cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len_%h: got %0d bytes first=%h writes=%0d cpu_rst=%b, want 1 byte ee 0 writes cpu_rst=0",
                     lens[i], got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, got_wr.size(), o_cpu_rst);
         end
      end
      n_cmp++;
      if (o_loaded !== m_loaded) begin
         n_fail++;
         $display("FAIL bad_len_loaded: got %b, want %b", o_loaded, m_loaded);
      end
   endtask

   task automatic test_timeout();
      bit mid_rst;
      int mid_tx;
      got_tx.delete(); got_wr.delete();
      send_byte(8'h07, 3);
      send_byte(8'h01, 3);
      send_byte(8'h03, 3);
      send_byte(8'h00, 3);
      m_loaded = 0; m_run = 0;
      repeat (TMO / 2) tick();
      mid_rst = o_cpu_rst;
      mid_tx  = got_tx.size();
      repeat (TMO / 2 + 30) tick();
      n_cmp++;
      if (!mid_rst || mid_tx != 0) begin
         n_fail++;
         $display("FAIL timeout_early: got cpu_rst=%b tx=%0d halfway, want 1 and 0", mid_rst, mid_tx);
      end
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== NAK || got_wr.size() != 0 ||
          o_loaded !== 1'b0 || o_cpu_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout: got %0d bytes first=%h writes=%0d loaded=%b cpu_rst=%b, want 1 byte ee 0 0 0",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, got_wr.size(), o_loaded, o_cpu_rst);
      end
   endtask

   task automatic test_busy();
      logic [7:0] e1, e2;
      i_tx_busy = 1'b1;
      got_tx.delete();
      e1 = ref_cmd(8'h09);
      send_byte(8'h09, 6);
      e2 = ref_cmd(8'hFF);
      send_byte(8'hFF, 6);
      repeat (6) tick();
      n_cmp++;
      if (got_tx.size() != 0) begin
         n_fail++;
         $display("FAIL busy_hold: got %0d starts while busy, want 0 (first queued %h)", got_tx.size(), e1);
      end
      i_tx_busy = 1'b0;
      repeat (10) tick();
      n_cmp++;
      if (got_tx.size() != 1 || got_tx[0] !== e2) begin
         n_fail++;
         $display("FAIL busy_release: got %0d starts first=%h, want 1 start %h",
                  got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, e2);
      end
   endtask

   task automatic test_random();
      logic [7:0] b, exp;
      logic [31:0] w[$];
      int s0;
      s0 = step_pulses - m_steps;
      for (int it = 0; it < 40; it++) begin
         int sel;
         sel = $urandom_range(0, 6);
         if (sel == 6) begin
            int n;
            n = $urandom_range(1, 4);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            load_prog(n, w);
            n_cmp++;
            if (got_wr.size() != n || got_tx.size() != 1 || got_tx[0] !== ACK ||
                (n > 0 && got_wr[n-1] !== {32'(n-1), w[n-1]})) begin
               n_fail++;
               $display("FAIL rnd_load_%0d: got %0d writes %0d bytes, want %0d writes and ack", it,
                        got_wr.size(), got_tx.size(), n);
            end
         end else begin
            if (sel < 4) b = 8'h08 + 8'(sel);
            else do b = 8'($urandom); while (b >= 8'h07 && b <= 8'h0B);
            send_cmd(b, exp);
            n_cmp++;
            if (got_tx.size() != 1 || got_tx[0] !== exp) begin
               n_fail++;
               $display("FAIL rnd_cmd_%0d_%h: got %0d bytes first=%h, want %h",
                        it, b, got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, exp);
            end
         end
         n_cmp++;
         if (o_run !== m_run || o_step_mode !== m_step_mode || o_loaded !== m_loaded) begin
            n_fail++;
            $display("FAIL rnd_state_%0d: got run/mode/loaded=%b%b%b, want %b%b%b", it,
                     o_run, o_step_mode, o_loaded, m_run, m_step_mode, m_loaded);
         end
      end
      n_cmp++;
      if (step_pulses - m_steps != s0 || step_dbl) begin
         n_fail++;
         $display("FAIL rnd_steps: got %0d pulses wide=%b, want %0d wide=0",
                  step_pulses - s0, step_dbl, m_steps);
      end
   endtask

   task automatic test_reset_midload();
      logic [7:0] exp;
      bit pre_rst;
      got_wr.delete();
      send_byte(8'h07, 4);
      send_byte(8'h02, 4);
      for (int k = 0; k < 5; k++) send_byte(8'($urandom), 2);
      pre_rst = o_cpu_rst;
      #3 i_rst = 1'b0;
      #1;
      n_cmp++;
      if (!pre_rst || {o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
                       o_cpu_rst, o_run, o_step, o_step_mode, o_loaded} !== '0) begin
         n_fail++;
         $display("FAIL reset_midload: got pre_cpu_rst=%b cpu_rst=%b we=%b loaded=%b mode=%b, want 1 then all 0",
                  pre_rst, o_cpu_rst, o_imem_we, o_loaded, o_step_mode);
      end
      m_loaded = 0; m_run = 0; m_step_mode = 0;
      repeat (3) tick();
      i_rst = 1'b1;
      got_wr.delete();
      repeat (10) tick();
      send_cmd(8'h08, exp);
      n_cmp++;
      if (got_wr.size() != 0 || got_tx.size() != 1 || got_tx[0] !== exp || o_run !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset: got writes=%0d %0d bytes first=%h run=%b, want 0 writes 1 byte %h run=0",
                  got_wr.size(), got_tx.size(), got_tx.size() ? got_tx[0] : 8'h00, o_run, exp);
      end
   endtask

   initial begin
      test_reset();
      test_no_load();
      test_load();
      test_run_halt();
      test_step();
      test_bad_len();
      test_timeout();
      test_busy();
      test_random();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
